data_mem_responder: RTL and testbench

- Memory-side responder for the CPU datapath's load/store port. It answers word read/write requests over a valid/ready request channel and a valid/ready response channel.
- A programmable number of wait states separates request acceptance from the response. This models multi-cycle memory ahead of the datapath moving off single-cycle memory.
- Holds a word-addressed RAM, commits stores, returns load data, and flags misaligned or out-of-range accesses.

---
 rtl/data_mem_responder.sv | 92 +++++++++
 tb/tb_data_mem_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM behind valid/ready request and response channels with programmable wait states.
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_write/req_addr/req_wdata request channel;
//        resp_valid/resp_ready/resp_rdata/resp_error response channel.
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [3:0] WS_M1 = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
   state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d, err_q, err_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [31:0] mem [2**ADDR_WIDTH];
   logic        c_write, c_err, commit;
   logic [31:0] c_addr, c_wdata;
   logic [ADDR_WIDTH-1:0] idx;
   // With zero wait states the commit edge is the accept edge, so the live request is used directly.
   always_comb begin
      c_write = state_q == IDLE ? req_write : wr_q;
      c_addr  = state_q == IDLE ? req_addr : addr_q;
      c_wdata = state_q == IDLE ? req_wdata : wdata_q;
      idx     = c_addr[ADDR_WIDTH+1:2];
      c_err   = (c_addr[1:0] != 2'b00) || ((c_addr >> (ADDR_WIDTH + 2)) != 32'd0);
      commit  = state_q == IDLE ? (req_valid && WAIT_STATES == 0) : (state_q == WAIT && cnt_q == 4'd0);
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      if (state_q == IDLE && req_valid) begin
         wr_d    = req_write;
         addr_d  = req_addr;
         wdata_d = req_wdata;
         cnt_d   = WS_M1;
         state_d = WAIT_STATES == 0 ? RESP : WAIT;
      end
      if (state_q == WAIT && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      if (commit) begin
         state_d = RESP;
         rdata_d = (c_write || c_err) ? 32'd0 : mem[idx];
         err_d   = c_err;
      end
      if (state_q == RESP && resp_ready) begin
         state_d = IDLE;
         rdata_d = 32'd0;
         err_d   = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset && commit && c_write && !c_err) mem[idx] <= c_wdata;
   end
   assign req_ready  = state_q == IDLE;
   assign resp_valid = state_q == RESP;
   assign resp_rdata = rdata_q;
   assign resp_error = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder against a word-array model.
module tb_data_mem_responder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid [4];
   logic        req_ready [4];
   logic        req_write [4];
   logic [31:0] req_addr [4];
   logic [31:0] req_wdata [4];
   logic        resp_valid [4];
   logic        resp_ready [4];
   logic [31:0] resp_rdata [4];
   logic        resp_error [4];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] model [4][int];
   always #5 clk = ~clk;
   function automatic int ws_of(input int i);
      return i == 0 ? 2 : i == 1 ? 0 : i == 2 ? 1 : 5;
   endfunction
   for (genvar g = 0; g < 4; g++) begin : g_dut
      data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(g == 0 ? 2 : g == 1 ? 0 : g == 2 ? 1 : 5)) dut (
         .clk(clk), .reset(reset),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
         .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
         .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
         .resp_rdata(resp_rdata[g]), .resp_error(resp_error[g])
      );
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic txn(input int i, input bit wr, input logic [31:0] a, input logic [31:0] wd, input int hold);
      bit          err;
      logic [31:0] exp_rd;
      int          n;
      err    = (a % 4) != 0 || a >= 32'd4096;
      exp_rd = (wr || err) ? 32'd0 : model[i][int'(a / 4)];
      if (wr && !err) model[i][int'(a / 4)] = wd;
      check("idle_ready", {31'd0, req_ready[i]}, 32'd1);
      req_valid[i]  = 1'b1;
      req_write[i]  = wr;
      req_addr[i]   = a;
      req_wdata[i]  = wd;
      resp_ready[i] = hold == 0;
      @(posedge clk);
      #1 req_valid[i] = 1'b0;
      req_addr[i] = $urandom;
      req_wdata[i] = $urandom;
      n = 0;
      while (!resp_valid[i] && n <= 40) begin
         check("wait_ready_low", {31'd0, req_ready[i]}, 32'd0);
         @(posedge clk);
         #1 n++;
      end
      check("latency", n, ws_of(i));
      if (n > 40) return;
      for (int k = 0; k < (hold == 0 ? 1 : hold); k++) begin
         check("resp_valid", {31'd0, resp_valid[i]}, 32'd1);
         check("resp_ready_low", {31'd0, req_ready[i]}, 32'd0);
         check("rdata", resp_rdata[i], exp_rd);
         check("error", {31'd0, resp_error[i]}, {31'd0, err});
         if (hold != 0) begin
            @(posedge clk);
            #1;
         end
      end
      resp_ready[i] = 1'b1;
      @(posedge clk);
      #1 resp_ready[i] = 1'b0;
      check("done_ready", {31'd0, req_ready[i]}, 32'd1);
      check("done_valid", {31'd0, resp_valid[i]}, 32'd0);
      check("done_rdata", resp_rdata[i], 32'd0);
   endtask
   initial begin
      for (int i = 0; i < 4; i++) begin
         req_valid[i] = 1'b0;
         req_write[i] = 1'b0;
         req_addr[i] = 32'd0;
         req_wdata[i] = 32'd0;
         resp_ready[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("rst_ready", {31'd0, req_ready[i]}, 32'd1);
         check("rst_valid", {31'd0, resp_valid[i]}, 32'd0);
         check("rst_rdata", resp_rdata[i], 32'd0);
         check("rst_error", {31'd0, resp_error[i]}, 32'd0);
      end
      for (int i = 0; i < 4; i++)
         for (int w = 0; w < 16; w++) txn(i, 1'b1, 32'(w * 4), $urandom, 0);
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
      txn(0, 1'b0, 32'h10, 32'd0, 0);
      for (int i = 1; i < 4; i++) txn(i, 1'b0, 32'h8, 32'd0, 0);
      txn(0, 1'b1, 32'h4, 32'h12345678, 0);
      txn(0, 1'b0, 32'h4, 32'd0, 7);
      txn(0, 1'b1, 32'h6, 32'hFFFFFFFF, 0);
      txn(0, 1'b0, 32'h4, 32'd0, 0);
      txn(0, 1'b0, 32'h1000, 32'd0, 0);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h20;
      req_wdata[0] = 32'hAAAAAAAA;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("midrst_ready", {31'd0, req_ready[0]}, 32'd1);
      check("midrst_valid", {31'd0, resp_valid[0]}, 32'd0);
      repeat (3) @(posedge clk);
      #1 txn(0, 1'b0, 32'h20, 32'd0, 0);
      for (int t = 0; t < 120; t++) begin
         int          i, kind;
         logic [31:0] a;
         i    = $urandom_range(3);
         kind = $urandom_range(5);
         a    = 32'($urandom_range(15) * 4);
         if (kind == 4) a = a + 32'($urandom_range(3, 1));
         if (kind == 5) a = $urandom | 32'h1000;
         txn(i, $urandom_range(1) == 1, a, $urandom, $urandom_range(3) == 0 ? $urandom_range(4, 1) : 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
